// File: rtl/brew_sequencer_if.sv
// Panel/sensor bundle for the brew-cycle controller.
// The master side (panel logic, sensors) drives requests; the slave side (sequencer) drives the actuators and status.
interface brew_sequencer_if;
   logic       start_req;
   logic [1:0] size_sel;
   logic       cancel;
   logic       water_ok;
   logic       temp_ok;
   logic       fault_clr;
   logic       heater_on;
   logic       pump_on;
   logic       valve_on;
   logic       busy;
   logic       done;
   logic       fault;
   logic [1:0] fault_code;
   logic [2:0] state_dbg;

   modport master (
      output start_req, size_sel, cancel, water_ok, temp_ok, fault_clr,
      input  heater_on, pump_on, valve_on, busy, done, fault, fault_code, state_dbg
   );

   modport slave (
      input  start_req, size_sel, cancel, water_ok, temp_ok, fault_clr,
      output heater_on, pump_on, valve_on, busy, done, fault, fault_code, state_dbg
   );
endinterface

// File: rtl/brew_sequencer.sv
// Timed brew-cycle controller: preheat -> brew -> drip -> done, with water-loss and preheat-timeout faults.
// All actuator/status outputs are registered from the next state so they switch on the same edge as the state.
module brew_sequencer #(
   parameter int unsigned PREHEAT_CYC   = 3000000,
   parameter int unsigned BREW_BASE_CYC = 2000000,
   parameter int unsigned DRIP_CYC      = 1000000
) (
   input logic            clk,
   input logic            rst_n,
   brew_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PREHEAT = 3'd1,
      BREW    = 3'd2,
      DRIP    = 3'd3,
      DONE    = 3'd4,
      FAULT   = 3'd5
   } state_t;

   localparam logic [31:0] PRE_LAST  = 32'(PREHEAT_CYC - 1);
   localparam logic [31:0] DRIP_LAST = 32'(DRIP_CYC - 1);
   localparam logic [31:0] BASE      = 32'(BREW_BASE_CYC);

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] len_q, len_d;
   logic [1:0]  code_q, code_d;
   logic        start_prev_q;
   logic        heater_q, heater_d;
   logic        pump_q, pump_d;
   logic        valve_q, valve_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        fault_q, fault_d;
   logic        start_rise;
   logic        timed;

   assign start_rise = bus.start_req & ~start_prev_q;
   assign timed      = (state_q == PREHEAT) || (state_q == BREW) || (state_q == DRIP);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      code_d  = code_q;
      unique case (state_q)
         IDLE: begin
            if (start_rise) begin
               if (bus.water_ok) begin
                  state_d = PREHEAT;
                  // Only the derived brew length is kept; it stands in for the latched size.
                  len_d   = (32'(bus.size_sel) + 32'd1) * BASE;
               end else begin
                  state_d = FAULT;
                  code_d  = 2'd1;
               end
            end
         end
         PREHEAT: begin
            if (bus.cancel)               state_d = IDLE;
            else if (bus.temp_ok)         state_d = BREW;
            else if (cnt_q == PRE_LAST) begin
               state_d = FAULT;
               code_d  = 2'd2;
            end
         end
         BREW: begin
            if (bus.cancel)               state_d = IDLE;
            else if (!bus.water_ok) begin
               state_d = FAULT;
               code_d  = 2'd1;
            end
            else if (cnt_q == len_q - 32'd1) state_d = DRIP;
         end
         DRIP: begin
            if (cnt_q == DRIP_LAST)       state_d = DONE;
         end
         DONE: state_d = IDLE;
         FAULT: begin
            if (bus.fault_clr && !bus.start_req) begin
               state_d = IDLE;
               code_d  = 2'd0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) cnt_d = '0;
      else if (timed)         cnt_d = cnt_q + 32'd1;
   end

   always_comb begin
      heater_d = (state_d == PREHEAT) || (state_d == BREW);
      pump_d   = (state_d == BREW);
      valve_d  = (state_d == BREW) || (state_d == DRIP);
      busy_d   = (state_d == PREHEAT) || (state_d == BREW) || (state_d == DRIP);
      done_d   = (state_d == DONE);
      fault_d  = (state_d == FAULT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         len_q        <= BASE;
         code_q       <= '0;
         start_prev_q <= 1'b1;
         heater_q     <= 1'b0;
         pump_q       <= 1'b0;
         valve_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         len_q        <= len_d;
         code_q       <= code_d;
         start_prev_q <= bus.start_req;
         heater_q     <= heater_d;
         pump_q       <= pump_d;
         valve_q      <= valve_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         fault_q      <= fault_d;
      end
   end

   assign bus.heater_on  = heater_q;
   assign bus.pump_on    = pump_q;
   assign bus.valve_on   = valve_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.fault      = fault_q;
   assign bus.fault_code = code_q;
   assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_brew_sequencer.sv
// Bench for brew_sequencer: stimulus queues the expected sequence of output vectors and how long
// the previous vector lasted; a negedge monitor pops one entry each time the output vector changes.
module tb_brew_sequencer;

   logic clk = 1'b0;
   logic rst_n;

   brew_sequencer_if bus();

   brew_sequencer #(
      .PREHEAT_CYC  (8),
      .BREW_BASE_CYC(4),
      .DRIP_CYC     (3)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] vec;
      int          run;   // cycles the previous vector lasted; 0 = not checked
      string       name;
   } exp_t;

   exp_t        q[$];
   exp_t        e;
   int          tests = 0;
   int          fails = 0;
   logic [10:0] cur;
   logic [10:0] prev = '0;
   int          run  = 0;

   // {state_dbg, heater, pump, valve, busy, done, fault, fault_code}
   localparam logic [10:0] V_IDLE  = {3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
   localparam logic [10:0] V_PRE   = {3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
   localparam logic [10:0] V_BREW  = {3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
   localparam logic [10:0] V_DRIP  = {3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
   localparam logic [10:0] V_DONE  = {3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
   localparam logic [10:0] V_FLT_W = {3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
   localparam logic [10:0] V_FLT_T = {3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};

   function automatic logic [10:0] outs();
      return {bus.state_dbg, bus.heater_on, bus.pump_on, bus.valve_on,
              bus.busy, bus.done, bus.fault, bus.fault_code};
   endfunction

   task automatic push(input logic [10:0] v, input int r, input string n);
      exp_t x;
      x.vec  = v;
      x.run  = r;
      x.name = n;
      q.push_back(x);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_now(input string n, input logic [10:0] got, input logic [10:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %b, expected %b", n, got, want);
      end
   endtask

   always @(negedge clk) begin
      cur = outs();
      if (cur !== prev) begin
         tests++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_change: got %b after %b (%0d cycles), nothing expected", cur, prev, run);
         end else begin
            e = q.pop_front();
            if (cur !== e.vec || (e.run != 0 && run != e.run)) begin
               fails++;
               $display("FAIL %s: got %b after %0d cycles, expected %b after %0d cycles",
                        e.name, cur, run, e.vec, e.run);
            end
         end
         prev = cur;
         run  = 1;
      end else begin
         run++;
      end
   end

   initial begin
      rst_n         = 1'b0;
      bus.start_req = 1'b0;
      bus.size_sel  = 2'd0;
      bus.cancel    = 1'b0;
      bus.water_ok  = 1'b1;
      bus.temp_ok   = 1'b0;
      bus.fault_clr = 1'b0;
      tick(2);
      chk_now("reset_state", outs(), V_IDLE);
      rst_n = 1'b1;
      tick(2);

      // Normal cycle, size 1: preheat 2, pump 8, drip 3, done 1
      push(V_PRE,  0, "norm_preheat");
      push(V_BREW, 2, "norm_brew");
      push(V_DRIP, 8, "norm_drip");
      push(V_DONE, 3, "norm_done");
      push(V_IDLE, 1, "norm_idle");
      bus.size_sel  = 2'd1;
      bus.start_req = 1'b1;
      tick(2);
      bus.temp_ok = 1'b1;
      tick(20);
      bus.temp_ok = 1'b0;

      // Preheat timeout, then fault clear rules
      push(V_PRE,   0, "to_preheat");
      push(V_FLT_T, 8, "to_fault");
      bus.start_req = 1'b0;
      tick(1);
      bus.start_req = 1'b1;
      tick(12);
      bus.fault_clr = 1'b1;
      tick(3);
      push(V_IDLE, 0, "to_clear");
      bus.start_req = 1'b0;
      tick(1);
      bus.fault_clr = 1'b0;
      tick(2);

      // Water loss on 5th brew cycle, size 3
      push(V_PRE,   0, "wl_preheat");
      push(V_BREW,  1, "wl_brew");
      push(V_FLT_W, 5, "wl_fault");
      bus.size_sel = 2'd3;
      bus.temp_ok  = 1'b1;
      tick(1);
      bus.start_req = 1'b1;
      tick(6);
      bus.water_ok = 1'b0;
      tick(3);
      push(V_IDLE, 0, "wl_clear");
      bus.start_req = 1'b0;
      bus.fault_clr = 1'b1;
      bus.water_ok  = 1'b1;
      tick(1);
      bus.fault_clr = 1'b0;
      tick(2);

      // Cancel in BREW: straight to IDLE, no done
      push(V_PRE,  0, "cb_preheat");
      push(V_BREW, 1, "cb_brew");
      push(V_IDLE, 1, "cb_idle");
      bus.size_sel  = 2'd0;
      bus.start_req = 1'b1;
      tick(2);
      bus.cancel = 1'b1;
      tick(1);
      bus.cancel = 1'b0;
      tick(3);

      // Cancel in DRIP: drain completes and done pulses
      push(V_PRE,  0, "cd_preheat");
      push(V_BREW, 1, "cd_brew");
      push(V_DRIP, 4, "cd_drip");
      push(V_DONE, 3, "cd_done");
      push(V_IDLE, 1, "cd_idle");
      bus.start_req = 1'b0;
      tick(1);
      bus.start_req = 1'b1;
      tick(6);
      bus.cancel = 1'b1;
      tick(6);
      bus.cancel = 1'b0;
      tick(2);

      // start_req high through reset release must not start a cycle
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(4);
      bus.start_req = 1'b0;
      tick(1);
      push(V_PRE,  0, "rs_preheat");
      push(V_BREW, 1, "rs_brew");
      push(V_IDLE, 1, "rs_async_idle");
      bus.start_req = 1'b1;
      tick(2);
      #2 rst_n = 1'b0;
      #1 chk_now("async_reset", outs(), V_IDLE);
      tick(3);
      rst_n = 1'b1;
      tick(4);

      // Start without water: FAULT code 1 directly, heater never on
      bus.start_req = 1'b0;
      bus.water_ok  = 1'b0;
      tick(1);
      push(V_FLT_W, 0, "nw_fault");
      bus.start_req = 1'b1;
      tick(3);
      push(V_IDLE, 0, "nw_clear");
      bus.start_req = 1'b0;
      bus.fault_clr = 1'b1;
      tick(1);
      bus.fault_clr = 1'b0;
      bus.water_ok  = 1'b1;
      tick(3);

      while (q.size() > 0) begin
         e = q.pop_front();
         tests++;
         fails++;
         $display("FAIL %s: never observed, expected %b", e.name, e.vec);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
